gain_ramp_limiter: RTL and testbench

- Post-FIR output stage on main_clk. Accepts one filtered 16-bit sample per handshake, applies a programmable Q2.14 gain and saturates the result to 16 bits.
- Gain changes and mute requests are ramped per sample to avoid zipper noise.
- Sits between the FIR result and the audio-clock output register.
- Counts clipping events for debug readout.

---
 rtl/gain_ramp_limiter.sv | 143 ++++++++++++++
 tb/tb_gain_ramp_limiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_ramp_limiter.sv
// gain_ramp_limiter: post-FIR output stage. Scales each accepted signed sample
// by a Q2.14 gain, rounds half up, saturates to 16 bits and hands it downstream.
// The gain moves toward its target, or toward 0 while muted, by at most
// RAMP_STEP per accepted sample.
// Ports:
//   main_clk, reset          sole clock, synchronous active-high reset
//   in_valid/in_ready/in_data    sample input handshake (signed 16-bit)
//   gain_load/gain_value     load unsigned Q2.14 target gain
//   mute                     level; while high the effective target is 0
//   out_valid/out_ready/out_data scaled, saturated output handshake
//   ramping                  current gain differs from effective target
//   clip_count/clip_clear    saturating clip counter and its clear
module gain_ramp_limiter #(
  parameter logic [15:0] UNITY     = 16'd16384,
  parameter logic [15:0] RAMP_STEP = 16'd1024
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        gain_load,
  input  logic [15:0] gain_value,
  input  logic        mute,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        ramping,
  output logic [15:0] clip_count,
  input  logic        clip_clear
);

  localparam int unsigned DW   = 16;
  localparam int unsigned GW   = 16;
  localparam int unsigned PW   = DW + GW + 1;
  localparam int unsigned FRAC = 14;

  localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  typedef enum logic [1:0] {IDLE, MUL, SAT, OUT} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic [GW-1:0]        cur_gain, target_gain, eff_target, cur_gain_nxt, op_gain;
  logic [GW:0]          up_sum, down_bound;
  logic signed [DW-1:0] sample_q;
  logic signed [PW-1:0] product, rounded;
  logic [DW-1:0]        sat_val;
  logic                 clipped;

  // State register
  always_ff @(posedge main_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and accept decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        accept    = 1'b1;
        state_nxt = MUL;
      end
      MUL:     state_nxt = SAT;
      SAT:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign eff_target = mute ? '0 : target_gain;
  assign ramping    = (cur_gain != eff_target);

  // One ramp step toward the effective target; 17-bit sums cannot wrap
  always_comb begin
    cur_gain_nxt = cur_gain;
    up_sum       = {1'b0, cur_gain} + {1'b0, RAMP_STEP};
    down_bound   = {1'b0, eff_target} + {1'b0, RAMP_STEP};
    if (cur_gain < eff_target) begin
      cur_gain_nxt = (up_sum > {1'b0, eff_target}) ? eff_target : up_sum[GW-1:0];
    end else if (cur_gain > eff_target) begin
      cur_gain_nxt = ({1'b0, cur_gain} > down_bound) ? (cur_gain - RAMP_STEP) : eff_target;
    end
  end

  // Round half up, then clamp to the 16-bit signed range
  always_comb begin
    rounded = (product + HALF) >>> FRAC;
    clipped = 1'b0;
    sat_val = rounded[DW-1:0];
    if (rounded > MAXV) begin
      sat_val = 16'h7FFF;
      clipped = 1'b1;
    end else if (rounded < MINV) begin
      sat_val = 16'h8000;
      clipped = 1'b1;
    end
  end

  // Datapath, gain and handshake registers
  always_ff @(posedge main_clk) begin
    if (reset) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      clip_count  <= '0;
      cur_gain    <= UNITY;
      target_gain <= UNITY;
      op_gain     <= UNITY;
      sample_q    <= '0;
      product     <= '0;
    end else begin
      in_ready <= (state_nxt == IDLE);
      if (gain_load) target_gain <= gain_value;
      // Operand is the gain before this sample's ramp step
      if (accept) begin
        sample_q <= in_data;
        op_gain  <= cur_gain;
        cur_gain <= cur_gain_nxt;
      end
      if (state == MUL) begin
        product <= $signed({{(PW-DW){sample_q[DW-1]}}, sample_q}) *
                   $signed({{(PW-GW){1'b0}}, op_gain});
      end
      if (state == SAT) begin
        out_data  <= sat_val;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clip_clear) begin
        clip_count <= '0;
      end else if (state == SAT && clipped && clip_count != 16'hFFFF) begin
        clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gain_ramp_limiter.sv
// Directed bench for gain_ramp_limiter with an arithmetic reference model.
module tb_gain_ramp_limiter;

  localparam int UNITY = 16384;
  localparam int RS    = 1024;

  logic        main_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        gain_load;
  logic [15:0] gain_value;
  logic        mute;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        ramping;
  logic [15:0] clip_count;
  logic        clip_clear;

  gain_ramp_limiter dut (
    .main_clk   (main_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .gain_load  (gain_load),
    .gain_value (gain_value),
    .mute       (mute),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ramping    (ramping),
    .clip_count (clip_count),
    .clip_clear (clip_clear)
  );

  always #5 main_clk = ~main_clk;

  typedef struct {
    int data;
    int clips;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   m_cur  = UNITY;
  int   m_target = UNITY;
  int   m_clips = 0;
  int   n_xfer = 0;
  bit   chk_en = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Output value of x scaled by Q2.14 gain g, rounded half up and clamped
  function automatic void scale(input int x, input int g, output int y, output bit clp);
    longint p, fl;
    p  = longint'(x) * longint'(g) + 64'sd8192;
    fl = p / 16384;
    if ((p % 16384) != 0 && p < 0) fl = fl - 1;
    clp = 1'b0;
    y   = int'(fl);
    if (fl > 32767)  begin y = 32767;  clp = 1'b1; end
    if (fl < -32768) begin y = -32768; clp = 1'b1; end
  endfunction

  function automatic int step(input int cur, input int eff);
    if (cur < eff) return (cur + RS > eff) ? eff : cur + RS;
    if (cur > eff) return (cur - RS < eff) ? eff : cur - RS;
    return cur;
  endfunction

  function automatic int eff_target();
    return mute ? 0 : m_target;
  endfunction

  // Compare process: ramping every cycle, each transferred output against the scoreboard
  always @(negedge main_clk) begin
    if (chk_en) begin
      chk("ramping", int'(ramping), int'(m_cur != eff_target()));
      if (out_valid && out_ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", int'($signed(out_data)), e.data);
          chk("clip_count", int'(clip_count), e.clips);
        end
      end
    end
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic send(input int x);
    int   n;
    int   y;
    bit   clp;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = 16'(x);
    tick();
    in_valid = 1'b0;
    scale(x, m_cur, y, clp);
    if (clp && m_clips < 65535) m_clips++;
    e.data  = y;
    e.clips = m_clips;
    q.push_back(e);
    m_cur = step(m_cur, eff_target());
  endtask

  // Send with out_ready high: out_valid must appear two edges after the accept
  task automatic send_lat(input int x, input int lit);
    send(x);
    tick();
    chk("latency_early", int'(out_valid), 0);
    tick();
    chk("latency_valid", int'(out_valid), 1);
    chk("literal_out", int'($signed(out_data)), lit);
  endtask

  task automatic load_gain(input int v);
    gain_load  = 1'b1;
    gain_value = 16'(v);
    tick();
    gain_load = 1'b0;
    m_target  = v;
  endtask

  task automatic settle();
    for (int i = 0; i < 80 && m_cur != eff_target(); i++) send(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; gain_load = 1'b0;
    gain_value = '0; mute = 1'b0; out_ready = 1'b1; clip_clear = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_clip_count", int'(clip_count), 0);
    chk("rst_ramping", int'(ramping), 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", int'(in_ready), 1);

    // Unity pass-through
    send_lat(1000, 1000);
    send_lat(-1000, -1000);
    tick();
    chk("unity_clips", int'(clip_count), 0);

    // Ramp down to 0
    load_gain(0);
    for (int k = 0; k < 18; k++) begin
      send_lat(16384, (k < 16) ? 16384 - RS * k : 0);
      if (k == 14) chk("ramp_15th", int'(ramping), 1);
      if (k == 15) chk("ramp_16th", int'(ramping), 0);
    end

    // Mute and unmute
    load_gain(UNITY);
    settle();
    mute = 1'b1;
    for (int k = 0; k < 16; k++) send(16384);
    send_lat(16384, 0);
    mute = 1'b0;
    for (int k = 0; k <= 16; k++) send_lat(16384, RS * k);

    // Saturation and clip counter clear
    load_gain(32768);
    settle();
    send_lat(20000, 32767);
    send_lat(-20000, -32768);
    tick();
    chk("clip_two", int'(clip_count), 2);
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    m_clips = 0;
    chk("clip_cleared", int'(clip_count), 0);

    // Backpressure
    load_gain(UNITY);
    settle();
    repeat (4) tick();
    out_ready = 1'b0;
    send(1234);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("bp_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    in_data  = 16'(-5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", int'($signed(out_data)), 1234);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    base      = n_xfer;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_one_xfer", n_xfer - base, 1);

    // Rounding
    load_gain(8192);
    settle();
    send_lat(1, 1);
    send_lat(-1, 0);
    repeat (2) tick();

    // Reset while the sample is in MUL
    in_valid = 1'b1;
    in_data  = 16'd100;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    m_cur = UNITY; m_target = UNITY; m_clips = 0;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_no_out", int'(out_valid), 0);
    end
    chk("mid_rst_ramping", int'(ramping), 0);
    send_lat(3000, 3000);

    repeat (6) tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
